// File: rtl/text_pkg.sv
// text_pkg: shared sizes, character codes, FSM state type and helpers for
// the text writer block.
//   DEF_COLS/DEF_ROWS : default screen geometry (40 x 25)
//   ADDR_W/DATA_W     : character-memory address and data widths
//   COL_W/ROW_W       : cursor column/row widths
package text_pkg;

    localparam int unsigned DEF_COLS = 40;
    localparam int unsigned DEF_ROWS = 25;
    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned COL_W    = 6;
    localparam int unsigned ROW_W    = 5;

    localparam logic [DATA_W-1:0] CH_SPACE = 8'h20;
    localparam logic [DATA_W-1:0] CH_TILDE = 8'h7E;
    localparam logic [DATA_W-1:0] CH_LF    = 8'h0A;
    localparam logic [DATA_W-1:0] CH_CR    = 8'h0D;
    localparam logic [DATA_W-1:0] CH_BS    = 8'h08;
    localparam logic [DATA_W-1:0] CH_FF    = 8'h0C;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Bytes that are drawn as glyphs rather than interpreted as controls.
    function automatic logic is_printable(input logic [DATA_W-1:0] b);
        return (b >= CH_SPACE) && (b <= CH_TILDE);
    endfunction

endpackage

// File: rtl/text_writer_if.sv
// text_writer_if: byte input stream, character-memory write port and status.
//   in_valid/in_data/in_ready : incoming byte handshake
//   w_en/w_addr/w_data        : character-memory write strobe/address/data
//   cursor_col/cursor_row     : current cursor position
//   busy                      : screen clear in progress
// master = byte source / memory side, slave = text_writer.
interface text_writer_if;
    import text_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [COL_W-1:0]  cursor_col;
    logic [ROW_W-1:0]  cursor_row;
    logic              busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, w_en, w_addr, w_data, cursor_col, cursor_row, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, w_en, w_addr, w_data, cursor_col, cursor_row, busy
    );

endinterface

// File: rtl/text_cursor.sv
// text_cursor: screen cursor row/column counters with wrap-around.
//   clk, rst  : clock, synchronous active-high reset
//   advance   : move right one cell, wrapping to the next row at the edge
//   newline   : column 0, next row
//   ret       : column 0, same row
//   back      : move left one cell unless already at column 0
//   home      : jump to (0,0)
//   col, row  : registered cursor position
// Rows wrap from ROWS-1 back to 0 (no scrolling).
module text_cursor
    import text_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             newline,
    input  logic             ret,
    input  logic             back,
    input  logic             home,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row
);

    logic [ROW_W-1:0] row_inc_c;

    // Next row with wrap to the top of the screen.
    always_comb begin
        row_inc_c = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (home) begin
            col <= '0;
            row <= '0;
        end else if (newline) begin
            col <= '0;
            row <= row_inc_c;
        end else if (ret) begin
            col <= '0;
        end else if (back) begin
            if (col != '0) begin
                col <= col - COL_W'(1);
            end
        end else if (advance) begin
            if (col == COL_W'(COLS - 1)) begin
                col <= '0;
                row <= row_inc_c;
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/text_writer.sv
// text_writer: turns a stream of character bytes into character-memory
// writes, handling LF, CR, BS and FF (screen clear) control codes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : text_writer_if.slave (byte input, memory write port, cursor,
//              busy)
// Build option: TEXT_WRITER_CLEAR_ON_RESET_EN makes the block clear the
// screen immediately after reset instead of starting in IDLE.
module text_writer
    import text_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic         clk,
    input  logic         rst,
    text_writer_if.slave bus
);

    localparam int unsigned CELLS = COLS * ROWS;
    // One extra bit so the count can reach CELLS when the screen is 16384 cells.
    localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
    localparam logic CLEAR_ON_RESET = 1'b1;
`else
    localparam logic CLEAR_ON_RESET = 1'b0;
`endif

    state_t            state, next_state;
    logic              in_ready_q, busy_q, w_en_q, start_clr;
    logic [ADDR_W-1:0] w_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [CNT_W-1:0]  clr_cnt, clr_cnt_nxt;
    logic              w_en_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              advance, newline, ret, back, home;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              accept_c;
    logic [ADDR_W-1:0] cur_addr_c;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .newline (newline),
        .ret     (ret),
        .back    (back),
        .home    (home),
        .col     (col),
        .row     (row)
    );

    assign accept_c   = bus.in_valid & in_ready_q;
    assign cur_addr_c = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

    // Next state, next write and cursor controls.
    always_comb begin
        next_state  = state;
        clr_cnt_nxt = clr_cnt;
        w_en_nxt    = 1'b0;
        w_addr_nxt  = w_addr_q;
        w_data_nxt  = w_data_q;
        advance     = 1'b0;
        newline     = 1'b0;
        ret         = 1'b0;
        back        = 1'b0;
        home        = 1'b0;
        case (state)
            IDLE: begin
                if (start_clr || (accept_c && bus.in_data == CH_FF)) begin
                    // First clear write (address 0) goes out with the state change.
                    next_state  = CLEAR;
                    home        = 1'b1;
                    w_en_nxt    = 1'b1;
                    w_addr_nxt  = '0;
                    w_data_nxt  = CH_SPACE;
                    clr_cnt_nxt = CNT_W'(1);
                end else if (accept_c) begin
                    if (is_printable(bus.in_data)) begin
                        w_en_nxt   = 1'b1;
                        w_addr_nxt = cur_addr_c;
                        w_data_nxt = bus.in_data;
                        advance    = 1'b1;
                    end else if (bus.in_data == CH_LF) begin
                        newline = 1'b1;
                    end else if (bus.in_data == CH_CR) begin
                        ret = 1'b1;
                    end else if (bus.in_data == CH_BS && col != '0) begin
                        // Erase the cell the cursor moves back onto.
                        back       = 1'b1;
                        w_en_nxt   = 1'b1;
                        w_addr_nxt = cur_addr_c - ADDR_W'(1);
                        w_data_nxt = CH_SPACE;
                    end
                end
            end
            CLEAR: begin
                if (clr_cnt == CNT_W'(CELLS)) begin
                    next_state = IDLE;
                end else begin
                    w_en_nxt    = 1'b1;
                    w_addr_nxt  = ADDR_W'(clr_cnt);
                    w_data_nxt  = CH_SPACE;
                    clr_cnt_nxt = clr_cnt + CNT_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            clr_cnt    <= '0;
            start_clr  <= CLEAR_ON_RESET;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state == IDLE);
            busy_q     <= (next_state == CLEAR);
            w_en_q     <= w_en_nxt;
            w_addr_q   <= w_addr_nxt;
            w_data_q   <= w_data_nxt;
            clr_cnt    <= clr_cnt_nxt;
            start_clr  <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = busy_q;
    assign bus.w_en       = w_en_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.w_data     = w_data_q;
    assign bus.cursor_col = col;
    assign bus.cursor_row = row;

endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed and randomized stimulus for text_writer, checked
// against a cursor/screen model kept in plain integer arithmetic.
module tb_text_writer;
    import text_pkg::*;

    localparam int COLS = 40;
    localparam int ROWS = 25;
    localparam int N    = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    int         m_col = 0;
    int         m_row = 0;
    logic [7:0] m_mem [N];
    logic [7:0] s_mem [N];

    text_writer_if bus();

    text_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Screen image as actually written by the DUT.
    always @(posedge clk) begin
        if (bus.w_en === 1'b1 && int'(bus.w_addr) < N) s_mem[bus.w_addr] <= bus.w_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Screen semantics: what one accepted byte writes and where the cursor goes.
    task automatic model_step(input logic [7:0] b, output bit we, output int addr,
                              output logic [7:0] d);
        we = 1'b0; addr = 0; d = 8'h20;
        if (b >= 8'h20 && b <= 8'h7E) begin
            we = 1'b1; addr = m_row * COLS + m_col; d = b;
            m_mem[addr] = b;
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                we = 1'b1; addr = m_row * COLS + m_col;
                m_mem[addr] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            m_col = 0; m_row = 0;
            we = 1'b1; addr = 0;
            foreach (m_mem[i]) m_mem[i] = 8'h20;
        end
    endtask

    task automatic check_cycle(input string tag, input bit we, input int addr, input logic [7:0] d);
        chk({tag, "_wen"}, 32'(bus.w_en), 32'(we));
        if (we) begin
            chk({tag, "_addr"}, 32'(bus.w_addr), 32'(addr));
            chk({tag, "_data"}, 32'(bus.w_data), 32'(d));
        end
        chk({tag, "_col"}, 32'(bus.cursor_col), 32'(m_col));
        chk({tag, "_row"}, 32'(bus.cursor_row), 32'(m_row));
    endtask

    // Present one byte, wait (bounded) for acceptance, check the cycle after.
    task automatic send(input logic [7:0] b, input string tag);
        int         waited = 0;
        bit         we;
        int         addr;
        logic [7:0] d;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 2 * N) begin
            tick();
            waited++;
        end
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        model_step(b, we, addr, d);
        check_cycle(tag, we, addr, d);
    endtask

    // Entered on clear cycle 1; leaves on cycle N+1.
    task automatic clear_follow(input string tag);
        int bad = 0;
        for (int k = 1; k <= N; k++) begin
            if (bus.w_en !== 1'b1 || bus.w_addr !== 14'(k - 1) || bus.w_data !== 8'h20 ||
                bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
            if (k < N) tick();
        end
        chk({tag, "_clear_cycles"}, 32'(bad), 32'd0);
        tick();
        chk({tag, "_end_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_end_wen"}, 32'(bus.w_en), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wen"}, 32'(bus.w_en), 32'd0);
        chk({tag, "_addr"}, 32'(bus.w_addr), 32'd0);
        chk({tag, "_data"}, 32'(bus.w_data), 32'd0);
        chk({tag, "_col"}, 32'(bus.cursor_col), 32'd0);
        chk({tag, "_row"}, 32'(bus.cursor_row), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        bit         we;
        int         addr;
        int         bad;
        logic [7:0] d;
        logic [7:0] b;
        int         r;

        // Reset with a byte offered: it must not be taken.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h41;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
        clear_follow("por_clear");
`else
        chk("post_reset_ready", 32'(bus.in_ready), 32'd1);
        chk("post_reset_wen", 32'(bus.w_en), 32'd0);
`endif
        m_col = 0; m_row = 0;

        // Two back-to-back printables.
        send(8'h41, "ab0");
        send(8'h42, "ab1");
        chk("ab_col", 32'(bus.cursor_col), 32'd2);
        chk("ab_row", 32'(bus.cursor_row), 32'd0);

        // Clear with in_valid held high throughout; held byte lands after.
        send(8'h0C, "ff_held");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h58;
        clear_follow("ff_held");
        tick();
        bus.in_valid = 1'b0;
        model_step(8'h58, we, addr, d);
        check_cycle("held_byte", we, addr, d);
        chk("held_byte_addr0", 32'(bus.w_addr), 32'd0);

        // One full row, then the rest of the screen to wrap to (0,0).
        send(8'h0C, "ff_row");
        clear_follow("ff_row");
        for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)), "row");
        chk("row_last_addr", 32'(bus.w_addr), 32'd39);
        chk("row_col", 32'(bus.cursor_col), 32'd0);
        chk("row_row", 32'(bus.cursor_row), 32'd1);
        for (int i = COLS; i < N; i++) send(8'($urandom_range(32, 126)), "fill");
        chk("wrap_col", 32'(bus.cursor_col), 32'd0);
        chk("wrap_row", 32'(bus.cursor_row), 32'd0);

        // Backspace from (5,3), then CR/LF, then backspace at column 0.
        repeat (3) send(8'h0A, "lf");
        repeat (5) send(8'($urandom_range(32, 126)), "pos");
        send(8'h08, "bs");
        chk("bs_addr", 32'(bus.w_addr), 32'd124);
        chk("bs_data", 32'(bus.w_data), 32'h20);
        chk("bs_col", 32'(bus.cursor_col), 32'd4);
        chk("bs_row", 32'(bus.cursor_row), 32'd3);
        send(8'h0D, "cr");
        send(8'h0A, "crlf");
        chk("crlf_col", 32'(bus.cursor_col), 32'd0);
        chk("crlf_row", 32'(bus.cursor_row), 32'd4);
        send(8'h08, "bs_col0");

        // Random mix of printables, controls and ignored bytes.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 78) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 94) b = 8'h08;
            else if (r < 97) b = 8'($urandom_range(128, 255));
            else             b = 8'h07;
            send(b, "rand");
        end
        tick();
        bad = 0;
        for (int i = 0; i < N; i++) if (s_mem[i] !== m_mem[i]) bad++;
        chk("screen_image", 32'(bad), 32'd0);

        // Reset during a clear: the clear stops and outputs return to reset.
        send(8'h0C, "ff_abort");
        for (int k = 2; k <= 500; k++) tick();
        rst = 1'b1;
        tick();
        check_reset_values("abort");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h41;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.w_en !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        m_col = 0; m_row = 0;
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
        clear_follow("abort_por");
`else
        chk("abort_release_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_release_wen", 32'(bus.w_en), 32'd0);
`endif
        send(8'h07, "bell");
        tick();
        chk("bell_quiet_wen", 32'(bus.w_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
